replicate_stream: RTL and testbench
===================================

# replicate_stream

Parametrised, handshaked replication engine. It generalises the fixed `{a, {4{b[0]}}, c[1]}` style of concatenation into a runtime-controlled streaming block. Each accepted input word is either fanned out into one wide beat holding N packed copies, or re-emitted as N consecutive beats. It sits between a narrow producer and wide or bursty consumers, with valid/ready flow control on both sides.

## Interface
- `DATA_W`, default 2: width of one input word; must be ≥ 1.
- `MAX_REP`, default 8: maximum replication count; must be ≥ 1.
- `CNT_W`, default `$clog2(MAX_REP+1)`: width of the count fields.
- `OUT_W`, derived as `DATA_W*MAX_REP`: output beat width.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst`  in  1  Synchronous reset, active-high.
- `in_valid`  in  1  Input word is presented.
- `in_ready`  out  1  Block will accept the input this cycle.
- `in_data`  in  DATA_W  Word to replicate.
- `in_rep`  in  CNT_W  Replication count N.
- `in_mode`  in  1  0 = word-repeat (N beats); 1 = fan-out (1 beat of N packed copies).
- `out_valid`  out  1  Output beat is presented.
- `out_ready`  in  1  Consumer accepts the beat.
- `out_data`  out  OUT_W  Beat payload; unused upper bits are 0.
- `out_last`  out  1  Final beat of the current input word.
- `out_idx`  out  CNT_W  Beat index within the word, 0-based; always 0 in fan-out mode.

## Operation
- An input is accepted on a cycle with `in_valid && in_ready`. An output beat is transferred on a cycle with `out_valid && out_ready`.
- N for an accepted word:
  - N = `in_rep`, clamped to `MAX_REP` when `in_rep > MAX_REP`.
  - When `in_rep == 0`, the word is accepted and discarded. No beat is produced and no state changes.
- Fan-out mode (`in_mode=1`):
  - One beat with `out_data[DATA_W*N-1:0] = {N{in_data}}` and upper bits 0.
  - `out_last=1`, `out_idx=0`.
- Word-repeat mode (`in_mode=0`):
  - N beats, each with `out_data[DATA_W-1:0] = in_data` and upper bits 0.
  - `out_idx` counts 0..N-1; `out_last=1` only on beat N-1.
- The block has two states:
  - IDLE: `out_valid=0`.
  - EMIT: `out_valid=1`, with a remaining-beats counter `rem`.
- IDLE → EMIT on accepting a word with N ≥ 1. `rem` is loaded with N-1 and `out_idx` with 0.
- In EMIT, on a transfer:
  - If `rem > 0`: decrement `rem`, increment `out_idx`, hold `out_data`, and set `out_last` when the new `rem == 0`.
  - If `rem == 0` (last beat): either go to IDLE, or reload directly from a word accepted in the same cycle (back-to-back).
- `in_ready = !rst && (!out_valid || (out_ready && out_last))`. This is combinational, so no bubble is needed between words.
- `in_mode` and `in_rep` are sampled only at acceptance. Changing them mid-burst has no effect on the burst in progress.
- The output payload, `out_last` and `out_idx` are held stable while `out_valid && !out_ready`.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `out_idx=0`, `rem=0`, state IDLE. `in_ready=0` while `rst` is high and 1 on the first cycle after.
- Latency: a word accepted at edge k appears with `out_valid=1` after edge k, i.e. one cycle later.
- Throughput:
  - Fan-out mode: one word per cycle when `out_ready` is held high.
  - Word-repeat mode: N beats per word with no idle cycles between words.
- Reset mid-burst: the burst is abandoned, all outputs return to reset values on the next edge, and no further beats are emitted.
- Simultaneous last-beat transfer and input acceptance: the new word's first beat is presented on the following cycle with `out_valid` staying high.
- A zero-count word accepted while the last beat transfers: the block goes to IDLE.

## Test plan
- Reset, then fan-out: DATA_W=2, MAX_REP=8; `in_data=2'b01`, `in_rep=4`, `in_mode=1`, `out_ready=1` → one cycle later `out_data=16'h0055`, `out_last=1`, `out_idx=0`; next cycle `out_valid=0`.
- Word-repeat: `in_data=2'b10`, `in_rep=3`, `in_mode=0` → three consecutive beats of `16'h0002` with `out_idx` 0, 1, 2; `out_last` high only on the third beat; `in_ready` low for the first two beats.
- Backpressure: same stimulus as the word-repeat test, with `out_ready=0` for 4 cycles on beat 1 → `out_data`, `out_idx=1` and `out_last=0` stay stable. The burst then completes with exactly 3 beats.
- Clamp and zero count: `in_rep=15` with `in_data=2'b11`, `in_mode=1` → `out_data=16'hFFFF`. Then `in_rep=0` → input accepted, no beat produced.
- Back-to-back plus mid-burst reset:
  - Two fan-out words in consecutive cycles → two consecutive beats with `out_valid` never dropping.
  - Assert `rst` during beat 2 of a 5-beat repeat → the next cycle shows all outputs 0 and no further beats.

Source files
------------

// File: rtl/replicate_stream_if.sv
// Handshake bundle for replicate_stream: narrow input word side and wide/bursty output side.
interface replicate_stream_if #(
  parameter int unsigned DATA_W  = 2,
  parameter int unsigned MAX_REP = 8,
  parameter int unsigned CNT_W   = $clog2(MAX_REP + 1),
  parameter int unsigned OUT_W   = DATA_W * MAX_REP
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CNT_W-1:0]  in_rep;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;
  logic [CNT_W-1:0]  out_idx;

  // Producer/consumer environment side
  modport master (
    output in_valid, in_data, in_rep, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_idx
  );

  // Replication engine side
  modport slave (
    input  in_valid, in_data, in_rep, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_last, out_idx
  );
endinterface

// File: rtl/replicate_stream.sv
// Replication engine: each accepted word becomes one fan-out beat of N packed copies
// or N consecutive repeat beats, with valid/ready flow control on both sides.
module replicate_stream #(
  parameter int unsigned DATA_W  = 2,
  parameter int unsigned MAX_REP = 8,
  parameter int unsigned CNT_W   = $clog2(MAX_REP + 1)
) (
  input  logic            clk,
  input  logic            rst,
  replicate_stream_if.slave bus
);
  localparam int unsigned OUT_W = DATA_W * MAX_REP;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               last_q, last_d;

  logic [CNT_W-1:0]   rep_n;
  logic [OUT_W-1:0]   fan_data;
  logic               accept;
  logic               xfer;

  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign bus.out_idx   = idx_q;

  // Ready is combinational so a new word can be taken on the last beat's transfer
  assign bus.in_ready = !rst && (!bus.out_valid || (bus.out_ready && last_q));
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = bus.out_valid && bus.out_ready;

  assign rep_n = (bus.in_rep > CNT_W'(MAX_REP)) ? CNT_W'(MAX_REP) : bus.in_rep;

  // N packed copies of the input word, zeros above
  always_comb begin
    fan_data = '0;
    for (int i = 0; i < int'(MAX_REP); i++) begin
      if (i < int'(rep_n)) fan_data[i*DATA_W +: DATA_W] = bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        if (accept && (rep_n != '0)) begin
          state_d = EMIT;
          idx_d   = '0;
          rem_d   = bus.in_mode ? '0 : rep_n - CNT_W'(1);
          last_d  = bus.in_mode || (rep_n == CNT_W'(1));
          data_d  = bus.in_mode ? fan_data : OUT_W'(bus.in_data);
        end
      end
      EMIT: begin
        if (xfer) begin
          if (rem_q != '0) begin
            rem_d  = rem_q - CNT_W'(1);
            idx_d  = idx_q + CNT_W'(1);
            last_d = (rem_q == CNT_W'(1));
          end else if (accept && (rep_n != '0)) begin
            // Back-to-back reload while the last beat leaves
            idx_d  = '0;
            rem_d  = bus.in_mode ? '0 : rep_n - CNT_W'(1);
            last_d = bus.in_mode || (rep_n == CNT_W'(1));
            data_d = bus.in_mode ? fan_data : OUT_W'(bus.in_data);
          end else begin
            state_d = IDLE;
            rem_d   = '0;
            idx_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_replicate_stream.sv
// Directed bench for replicate_stream (DATA_W=2, MAX_REP=8): fan-out, repeat,
// backpressure, clamp, zero count, back-to-back and mid-burst reset.
module tb_replicate_stream;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  replicate_stream_if #(.DATA_W(2), .MAX_REP(8)) bus ();

  replicate_stream #(.DATA_W(2), .MAX_REP(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] data, input logic [3:0] idx,
                          input logic last);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_data"},  32'(bus.out_data),  32'(data));
    chk({tag, "_idx"},   32'(bus.out_idx),   32'(idx));
    chk({tag, "_last"},  32'(bus.out_last),  32'(last));
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_rep    = '0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_out_idx",   32'(bus.out_idx),   32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Fan-out: 4 copies of 01 -> 0x0055
    bus.in_valid = 1'b1; bus.in_data = 2'b01; bus.in_rep = 4'd4; bus.in_mode = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk_beat("fan4", 16'h0055, 4'd0, 1'b1);
    tick();
    chk("fan4_done_valid", 32'(bus.out_valid), 32'd0);

    // Word-repeat: 3 beats of 10
    bus.in_valid = 1'b1; bus.in_data = 2'b10; bus.in_rep = 4'd3; bus.in_mode = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk_beat("rep_b0", 16'h0002, 4'd0, 1'b0);
    chk("rep_b0_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk_beat("rep_b1", 16'h0002, 4'd1, 1'b0);
    chk("rep_b1_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk_beat("rep_b2", 16'h0002, 4'd2, 1'b1);
    chk("rep_b2_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("rep_done_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure on beat 1 for 4 cycles; mode/rep changes mid-burst must not matter
    bus.in_valid = 1'b1; bus.in_data = 2'b10; bus.in_rep = 4'd3; bus.in_mode = 1'b0;
    tick();
    bus.in_valid = 1'b0; bus.in_mode = 1'b1; bus.in_rep = 4'd7;
    chk_beat("bp_b0", 16'h0002, 4'd0, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk_beat("bp_hold", 16'h0002, 4'd1, 1'b0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk_beat("bp_b1", 16'h0002, 4'd1, 1'b0);
    tick();
    chk_beat("bp_b2", 16'h0002, 4'd2, 1'b1);
    tick();
    chk("bp_done_valid", 32'(bus.out_valid), 32'd0);

    // Clamp: rep 15 -> 8 copies of 11
    bus.in_valid = 1'b1; bus.in_data = 2'b11; bus.in_rep = 4'd15; bus.in_mode = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk_beat("clamp", 16'hFFFF, 4'd0, 1'b1);
    tick();
    chk("clamp_done_valid", 32'(bus.out_valid), 32'd0);

    // Zero count: accepted, no beat
    bus.in_valid = 1'b1; bus.in_data = 2'b01; bus.in_rep = 4'd0; bus.in_mode = 1'b0;
    #1;
    chk("zero_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("zero_valid0", 32'(bus.out_valid), 32'd0);
    chk("zero_data0",  32'(bus.out_data),  32'd0);
    tick();
    chk("zero_valid1", 32'(bus.out_valid), 32'd0);

    // Back-to-back fan-out: 01 x2 then 10 x3
    bus.in_valid = 1'b1; bus.in_data = 2'b01; bus.in_rep = 4'd2; bus.in_mode = 1'b1;
    tick();
    bus.in_data = 2'b10; bus.in_rep = 4'd3;
    #1;
    chk_beat("b2b_w0", 16'h0005, 4'd0, 1'b1);
    chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk_beat("b2b_w1", 16'h002A, 4'd0, 1'b1);
    tick();
    chk("b2b_done_valid", 32'(bus.out_valid), 32'd0);

    // Single-beat repeat, then a zero-count word on its last beat -> IDLE
    bus.in_valid = 1'b1; bus.in_data = 2'b11; bus.in_rep = 4'd1; bus.in_mode = 1'b0;
    tick();
    bus.in_rep = 4'd0;
    #1;
    chk_beat("one_b0", 16'h0003, 4'd0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("zero_b2b_valid", 32'(bus.out_valid), 32'd0);

    // Mid-burst reset on beat 2 of a 5-beat repeat
    bus.in_valid = 1'b1; bus.in_data = 2'b01; bus.in_rep = 4'd5; bus.in_mode = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk_beat("mr_b0", 16'h0001, 4'd0, 1'b0);
    tick();
    chk_beat("mr_b1", 16'h0001, 4'd1, 1'b0);
    rst = 1'b1;
    #1;
    chk("mr_in_ready_rst", 32'(bus.in_ready), 32'd0);
    tick();
    chk("mr_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_data",  32'(bus.out_data),  32'd0);
    chk("mr_last",  32'(bus.out_last),  32'd0);
    chk("mr_idx",   32'(bus.out_idx),   32'd0);
    rst = 1'b0;
    tick();
    chk("mr_after_valid0", 32'(bus.out_valid), 32'd0);
    tick();
    chk("mr_after_valid1", 32'(bus.out_valid), 32'd0);
    chk("mr_after_ready",  32'(bus.in_ready),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
